// File: rtl/interrupt_controller_if.sv
// Interrupt controller bus bundle.
// Groups the interrupt request lines, the CPU register-write port, the
// instruction-retire strobes, the CPU req/ack handshake and the register
// readbacks.
//   master : CPU/system side, drives requests, writes, strobes and ack.
//   slave  : interrupt controller, drives readbacks, request and vector.
interface interrupt_controller_if #(
  parameter int unsigned NUM_SOURCES = 5
);
  logic [NUM_SOURCES-1:0] iIrqLines;
  logic                   iMcuWe;
  logic                   iMcuRegSelect;
  logic [7:0]             iMcuWriteData;
  logic                   iEi;
  logic                   iDi;
  logic                   iReti;
  logic                   iEof;
  logic                   iIrqAck;
  logic [7:0]             oIf;
  logic [7:0]             oIe;
  logic                   oIme;
  logic                   oIrqReq;
  logic [7:0]             oIrqVector;
  logic                   oWakeup;
  logic                   oInterrupt;

  modport master (
    output iIrqLines, iMcuWe, iMcuRegSelect, iMcuWriteData,
           iEi, iDi, iReti, iEof, iIrqAck,
    input  oIf, oIe, oIme, oIrqReq, oIrqVector, oWakeup, oInterrupt
  );

  modport slave (
    input  iIrqLines, iMcuWe, iMcuRegSelect, iMcuWriteData,
           iEi, iDi, iReti, iEof, iIrqAck,
    output oIf, oIe, oIme, oIrqReq, oIrqVector, oWakeup, oInterrupt
  );
endinterface

// File: rtl/interrupt_controller.sv
// Interrupt controller: holds IF, IE and the master enable IME, picks the
// lowest-numbered pending request and presents it with its vector to the
// CPU over a req/ack handshake. oInterrupt stays high from the dispatch
// until the next end-of-instruction so the timer can charge the dispatch.
// Ports:
//   iClock  system clock (posedge)
//   iReset  asynchronous active-low reset
//   bus     slave side of interrupt_controller_if
//           in : iIrqLines, iMcuWe, iMcuRegSelect, iMcuWriteData,
//                iEi, iDi, iReti, iEof, iIrqAck
//           out: oIf, oIe, oIme, oIrqReq, oIrqVector, oWakeup, oInterrupt
module interrupt_controller #(
  parameter int unsigned NUM_SOURCES   = 5,
  parameter logic [7:0]  VECTOR_BASE   = 8'h40,
  parameter logic [7:0]  VECTOR_STRIDE = 8'h08
) (
  input logic                   iClock,
  input logic                   iReset,
  interrupt_controller_if.slave bus
);

  localparam int unsigned SRC_W = NUM_SOURCES;
  localparam int unsigned IDX_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    DISPATCH = 2'd2,
    WAIT_EOF = 2'd3
  } stateT;

  stateT            rState, stateNext;
  logic [SRC_W-1:0] rIf, ifNext;
  logic [7:0]       rIe, ieNext;
  logic             rIme, imeNext;
  logic             rEiPend, eiPendNext;
  logic [IDX_W-1:0] rIdx, idxNext;
  logic             rIrqReq, reqNext;
  logic [7:0]       rVector, vectorNext;
  logic             rWakeup, wakeupNext;
  logic             rInterrupt, interruptNext;

  logic [SRC_W-1:0] wPend;
  logic [SRC_W-1:0] pendNext;
  logic             ackTaken;
  logic [7:0]       ifRead;

  // Lowest set bit wins (bit 0 is highest priority).
  function automatic logic [IDX_W-1:0] lowestIdx(input logic [SRC_W-1:0] v);
    lowestIdx = '0;
    for (int i = int'(SRC_W) - 1; i >= 0; i--) begin
      if (v[i]) lowestIdx = IDX_W'(i);
    end
  endfunction

  function automatic logic [7:0] vecOf(input logic [IDX_W-1:0] idx);
    vecOf = VECTOR_BASE + 8'(idx) * VECTOR_STRIDE;
  endfunction

  assign wPend = rIf & rIe[SRC_W-1:0];

  // State register and registered outputs.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      rState     <= IDLE;
      rIf        <= '0;
      rIe        <= '0;
      rIme       <= 1'b0;
      rEiPend    <= 1'b0;
      rIdx       <= '0;
      rIrqReq    <= 1'b0;
      rVector    <= VECTOR_BASE;
      rWakeup    <= 1'b0;
      rInterrupt <= 1'b0;
    end else begin
      rState     <= stateNext;
      rIf        <= ifNext;
      rIe        <= ieNext;
      rIme       <= imeNext;
      rEiPend    <= eiPendNext;
      rIdx       <= idxNext;
      rIrqReq    <= reqNext;
      rVector    <= vectorNext;
      rWakeup    <= wakeupNext;
      rInterrupt <= interruptNext;
    end
  end

  // Register updates, IME sequencing, FSM next state and next outputs.
  always_comb begin
    stateNext     = rState;
    ifNext        = rIf;
    ieNext        = rIe;
    imeNext       = rIme;
    eiPendNext    = rEiPend;
    idxNext       = rIdx;
    vectorNext    = VECTOR_BASE;
    pendNext      = '0;
    ackTaken      = 1'b0;
    reqNext       = 1'b0;
    wakeupNext    = 1'b0;
    interruptNext = 1'b0;

    if (bus.iMcuWe && bus.iMcuRegSelect) ieNext = bus.iMcuWriteData;

    // Write, then dispatch clear, then new pulses: a pulse always survives.
    if (bus.iMcuWe && !bus.iMcuRegSelect) ifNext = bus.iMcuWriteData[SRC_W-1:0];
    if (rState == DISPATCH) ifNext = ifNext & ~(SRC_W'(1) << rIdx);
    ifNext   = ifNext | bus.iIrqLines;
    pendNext = ifNext & ieNext[SRC_W-1:0];

    ackTaken = (rState == PENDING) && bus.iIrqAck;

    // EI takes effect at the end of the following instruction, not its own.
    if (rEiPend && bus.iEof) begin
      imeNext    = 1'b1;
      eiPendNext = 1'b0;
    end
    if (bus.iEi)   eiPendNext = 1'b1;
    if (bus.iReti) imeNext    = 1'b1;
    if (ackTaken || (rState == DISPATCH)) begin
      imeNext    = 1'b0;
      eiPendNext = 1'b0;
    end
    if (bus.iDi) begin
      imeNext    = 1'b0;
      eiPendNext = 1'b0;
    end

    case (rState)
      IDLE: begin
        // Only raise a request that will still be pending when it is seen.
        if (rIme && (wPend != '0) && (pendNext != '0) && imeNext) stateNext = PENDING;
      end
      PENDING: begin
        if (ackTaken) begin
          stateNext = DISPATCH;
          idxNext   = lowestIdx(wPend);
        end else if (!imeNext || (pendNext == '0)) begin
          stateNext = IDLE;
        end
      end
      DISPATCH: stateNext = WAIT_EOF;
      WAIT_EOF: if (bus.iEof) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase

    // Outputs are registered from next-cycle values so they line up with state.
    case (stateNext)
      PENDING:            vectorNext = vecOf(lowestIdx(pendNext));
      DISPATCH, WAIT_EOF: vectorNext = vecOf(idxNext);
      default:            vectorNext = VECTOR_BASE;
    endcase
    reqNext       = (stateNext == PENDING);
    interruptNext = (stateNext == DISPATCH) || (stateNext == WAIT_EOF);
    wakeupNext    = (pendNext != '0);
  end

  // Unimplemented IF bits read as 1.
  always_comb begin
    ifRead            = 8'hFF;
    ifRead[SRC_W-1:0] = rIf;
  end

  assign bus.oIf        = ifRead;
  assign bus.oIe        = rIe;
  assign bus.oIme       = rIme;
  assign bus.oIrqReq    = rIrqReq;
  assign bus.oIrqVector = rVector;
  assign bus.oWakeup    = rWakeup;
  assign bus.oInterrupt = rInterrupt;

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Downstream consumer of the timer block's overflow pulse (oInterrupt0x50), alongside the VBlank, LCD STAT, serial and joypad request pulses.
- Holds IF (0xFF0F), IE (0xFFFF) and the master enable IME, and arbitrates pending requests by fixed priority.
- Presents one request plus its vector to the CPU through a req/ack handshake.
- Drives the per-instruction oInterrupt flag that the timer block uses to account the 20-cycle dispatch cost.

Parameters:
- NUM_SOURCES, 5, number of interrupt lines (bit 0 has highest priority).
- VECTOR_BASE, 8'h40, vector address for bit 0.
- VECTOR_STRIDE, 8'h08, vector spacing between consecutive bits.

Ports:
- iClock  in  1  system clock, all state changes on posedge.
- iReset  in  1  reset, asynchronous, active-low.
- iIrqLines  in  NUM_SOURCES  one-cycle request pulses: [0] VBlank, [1] STAT, [2] timer (oInterrupt0x50), [3] serial, [4] joypad.
- iMcuWe  in  1  CPU register write strobe.
- iMcuRegSelect  in  1  target of the write: 0 = IF, 1 = IE.
- iMcuWriteData  in  8  write data.
- iEi  in  1  EI retired; pulse coincident with that instruction's iEof.
- iDi  in  1  DI retired.
- iReti  in  1  RETI retired.
- iEof  in  1  end-of-instruction strobe from the CPU.
- iIrqAck  in  1  CPU accepts the request; one-cycle pulse, sampled only while oIrqReq=1.
- oIf  out  8  IF readback; bits 7:5 read 1.
- oIe  out  8  IE readback; all 8 bits stored.
- oIme  out  1  master enable.
- oIrqReq  out  1  request to CPU.
- oIrqVector  out  8  dispatch address.
- oWakeup  out  1  (IF & IE & 5'h1F) != 0, independent of IME; used for HALT exit.
- oInterrupt  out  1  high from ack until the next iEof; feeds the timer block's iInterrupt.

Behaviour:

Reset (iReset=0):
- Clears rIf=0, rIe=0, IME=0 and EI-pending.
- State returns to IDLE; oIrqReq=0, oIrqVector=VECTOR_BASE, oInterrupt=0.
- Reset asserted mid-handshake aborts the handshake with no IF side effects.

IF update each cycle, in this order:
1. CPU write, if iMcuWe & sel=0: rIf <= data[4:0].
2. Dispatch clear of the latched bit.
3. OR in iIrqLines.
- Consequence: a source pulse never loses against a write or clear in the same cycle.

IE: written when iMcuWe & sel=1.

IME rules:
- iDi clears IME and cancels EI-pending. DI wins over a simultaneous EI.
- iReti sets IME immediately.
- iEi sets EI-pending. IME is set at the next iEof after the EI cycle, so there is a one-instruction delay.
- Ack clears IME and EI-pending.

Pending and priority:
- wPend = rIf & rIe[4:0].
- Selected bit = lowest set bit of wPend.
- Vector = VECTOR_BASE + idx*VECTOR_STRIDE, giving 0x40 / 0x48 / 0x50 / 0x58 / 0x60.

State machine:
- IDLE:
  - oIrqReq=0.
  - Go to PENDING when IME & (wPend != 0).
- PENDING:
  - oIrqReq=1; oIrqVector tracks the current highest priority each cycle, so a higher-priority arrival preempts before ack.
  - If wPend becomes 0 or IME is cleared before ack, return to IDLE (request withdrawn).
  - On iIrqAck: latch idx, go to DISPATCH.
- DISPATCH (one cycle):
  - Clear rIf[idx], clear IME, set oInterrupt; oIrqReq=0.
  - Vector stays at the latched value.
  - Go to WAIT_EOF.
- WAIT_EOF:
  - Hold oInterrupt=1 until iEof, then go to IDLE.
  - No new request may be raised in this state.

Latency:
- Source pulse in cycle N sets the IF bit visible at N+1.
- oIrqReq rises at N+2 when IE and IME are set.

Test Plan:
- Timer pulse with IE=0x04, IME=1 → oIf=0xE4 next cycle; oIrqReq=1 with vector 0x50 one cycle later; ack → oIf=0xE0, oIme=0, oInterrupt=1 until iEof.
- Pulses on iIrqLines=5'b10101 with IE=0x1F, IME=1 → vector 0x40; after ack, oIf=0xF4 and next vector 0x50 only after IME is re-set.
- EI at iEof, then the next instruction's iEof with IF=IE=0x01 → oIme rises only after the second iEof; DI on the same cycle as EI → IME stays 0.
- Request withdrawal: PENDING with vector 0x48, CPU writes IF=0x00 → oIrqReq drops next cycle, state IDLE, no ack side effects.
- Same-cycle conflicts:
  - Timer pulse in the DISPATCH cycle that clears bit 2 → bit 2 remains set.
  - Timer pulse during a CPU write of IF=0x00 → oIf=0xE4.
- IME=0, IF=0x02, IE=0x02 → oWakeup=1, oIrqReq=0. Asserting iReset mid-PENDING → all outputs at their reset values immediately.
